// File: rtl/checksum_stream_ctrl_if.sv
// Stream bundle for checksum_stream_ctrl: beat input (s_*), checksum result (m_*) and busy status.
// master = packet source / result consumer side, slave = checksum controller side.
interface checksum_stream_ctrl_if #(
  parameter int DATA_W = 64
);
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [DATA_W/8-1:0] s_keep;
  logic                s_last;
  logic [15:0]         seed;
  logic                m_valid;
  logic                m_ready;
  logic [15:0]         m_checksum;
  logic                busy;

  modport master (
    output s_valid, s_data, s_keep, s_last, seed, m_ready,
    input  s_ready, m_valid, m_checksum, busy
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, seed, m_ready,
    output s_ready, m_valid, m_checksum, busy
  );
endinterface

// File: rtl/checksum_stream_ctrl.sv
// 16-bit one's-complement checksum over a keep-masked multi-beat stream, folded and complemented.
// Optional macro CKSUM_UDP_ZERO_EN: a computed 16'h0000 is emitted as 16'hFFFF (UDP rule).
module checksum_stream_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  checksum_stream_ctrl_if.slave         bus
);

  localparam int N_BYTES = DATA_W / 8;
  localparam int N_WORDS = DATA_W / 16;
  localparam int SUM_W   = 16 + $clog2(N_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [15:0] m_checksum_q, m_checksum_d;
  logic        busy_q, busy_d;

  logic [DATA_W-1:0] masked_data;
  logic [SUM_W-1:0]  beat_sum;
  logic [31:0]       acc_base;
  logic [31:0]       acc_accum;
  logic [16:0]       fold_t;
  logic [15:0]       fold_sum;
  logic [15:0]       cksum;
  logic              beat_fire;

  assign beat_fire = bus.s_valid && s_ready_q;

  // Byte 0 on the wire sits in the top byte; its keep bit is the top keep bit.
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      masked_data[DATA_W-1-8*i -: 8] = bus.s_data[DATA_W-1-8*i -: 8] & {8{bus.s_keep[N_BYTES-1-i]}};
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      beat_sum = beat_sum + SUM_W'(masked_data[DATA_W-1-16*k -: 16]);
    end
  end

  // The seed replaces the accumulator on the first beat, so no residue survives between packets.
  always_comb begin
    acc_base  = (state_q == IDLE) ? {16'h0000, bus.seed} : acc_q;
    acc_accum = {16'h0000, acc_base[15:0]} + {16'h0000, acc_base[31:16]} + 32'(beat_sum);
  end

  // One end-around fold suffices: the accumulator's upper half never exceeds a few bits.
  always_comb begin
    fold_t   = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    fold_sum = fold_t[15:0] + {15'h0000, fold_t[16]};
`ifdef CKSUM_UDP_ZERO_EN
    cksum = (~fold_sum == 16'h0000) ? 16'hFFFF : ~fold_sum;
`else
    cksum = ~fold_sum;
`endif
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    m_checksum_d = m_checksum_q;
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          acc_d   = acc_accum;
          state_d = bus.s_last ? FOLD : ACC;
        end
      end
      ACC: begin
        if (beat_fire) begin
          acc_d = acc_accum;
          if (bus.s_last) begin
            state_d = FOLD;
          end
        end
      end
      FOLD: begin
        acc_d        = {16'h0000, fold_sum};
        m_checksum_d = cksum;
        state_d      = OUT;
      end
      OUT: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    s_ready_d = (state_d == IDLE) || (state_d == ACC);
    m_valid_d = (state_d == OUT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 32'h0000_0000;
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_checksum_q <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_checksum_q <= m_checksum_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_checksum = m_checksum_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_checksum_stream_ctrl.sv
// Directed self-checking bench for checksum_stream_ctrl (DATA_W=64), hand-computed expected checksums.
module tb_checksum_stream_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  checksum_stream_ctrl_if #(.DATA_W(64)) bus ();

  checksum_stream_ctrl #(.DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic [15:0] sd);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    bus.seed    = sd;
  endtask

  // Present one beat and wait (bounded) for the accepting edge; returns just after that edge.
  task automatic sendBeat(input string tag, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic [15:0] sd);
    bit accepted;
    accepted = 1'b0;
    applyStimulus(1'b1, d, k, l, sd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 16'h0000);
    if (!accepted) checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
  endtask

  // Called right after the edge accepting the last beat; checks latency, value, optional stall.
  task automatic waitResult(input string tag, input logic [15:0] exp, input int hold);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        cnt  = i;
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_latency"}, 32'(cnt), 32'd2);
      checkOutput({tag, "_cksum"}, 32'(bus.m_checksum), 32'(exp));
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
        checkOutput({tag, "_hold_valid"}, 32'(bus.m_valid), 32'd1);
        checkOutput({tag, "_hold_cksum"}, 32'(bus.m_checksum), 32'(exp));
        checkOutput({tag, "_hold_sready"}, 32'(bus.s_ready), 32'd0);
        @(negedge clk);
      end
      bus.m_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.m_ready = 1'b0;
    end
  endtask

  logic [15:0] exp_ffff_zero;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef CKSUM_UDP_ZERO_EN
    exp_ffff_zero = 16'hFFFF;
`else
    exp_ffff_zero = 16'h0000;
`endif
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_checksum", 32'(bus.m_checksum), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] IPv4 header, 3 beats");
    sendBeat("ipv4_b1", 64'h4500_0073_0000_4000, 8'hFF, 1'b0, 16'h0000);
    sendBeat("ipv4_b2", 64'h4011_0000_c0a8_0001, 8'hFF, 1'b0, 16'h0000);
    sendBeat("ipv4_b3", 64'hc0a8_00c7_1234_5678, 8'hF0, 1'b1, 16'h0000);
    waitResult("ipv4", 16'hB861, 0);

    $display("[TB] single zero beat");
    sendBeat("zero_b1", 64'h0, 8'hFF, 1'b1, 16'h0000);
    waitResult("zero", 16'hFFFF, 0);

    $display("[TB] sum of FFFF gives zero checksum");
    sendBeat("ffff_b1", 64'hFFFF_0000_0000_0000, 8'hFF, 1'b1, 16'h0000);
    waitResult("ffff", exp_ffff_zero, 0);

    $display("[TB] odd length with seed");
    sendBeat("odd_b1", 64'h0102_03AA_BBBB_BBBB, 8'hE0, 1'b1, 16'h0001);
    waitResult("odd", 16'hFBFC, 0);

    $display("[TB] non-contiguous keep");
    sendBeat("sparse_b1", 64'hAABB_CCDD_EEFF_1122, 8'h81, 1'b1, 16'h0000);
    waitResult("sparse", 16'h55DD, 0);

    $display("[TB] seed first beat only, empty last beat");
    sendBeat("seed_b1", 64'h0001_0002_0003_0004, 8'hFF, 1'b0, 16'h1000);
    sendBeat("seed_b2", 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 16'hFFFF);
    waitResult("seed", 16'hEFF5, 0);

    $display("[TB] end-around carry across beats");
    sendBeat("carry_b1", 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 16'h0000);
    sendBeat("carry_b2", 64'h0001_0000_0000_0000, 8'hFF, 1'b1, 16'h0000);
    waitResult("carry", 16'hFFFE, 0);

    $display("[TB] backpressure then back-to-back packet");
    sendBeat("bp_b1", 64'h0102_03AA_BBBB_BBBB, 8'hE0, 1'b1, 16'h0001);
    applyStimulus(1'b1, 64'h0, 8'hFF, 1'b1, 16'h0000);
    waitResult("bp", 16'hFBFC, 5);
    @(negedge clk);
    checkOutput("b2b_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("b2b_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 16'h0000);
    waitResult("b2b", 16'hFFFF, 0);

    $display("[TB] reset mid-packet");
    sendBeat("mid_b1", 64'h4500_0073_0000_4000, 8'hFF, 1'b0, 16'h0000);
    sendBeat("mid_b2", 64'h4011_0000_c0a8_0001, 8'hFF, 1'b0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("mid_rst_m_checksum", 32'(bus.m_checksum), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mid_no_m_valid", 32'(bus.m_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    sendBeat("post_b1", 64'h4500_0073_0000_4000, 8'hFF, 1'b0, 16'h0000);
    sendBeat("post_b2", 64'h4011_0000_c0a8_0001, 8'hFF, 1'b0, 16'h0000);
    sendBeat("post_b3", 64'hc0a8_00c7_0000_0000, 8'hF0, 1'b1, 16'h0000);
    waitResult("post", 16'hB861, 0);

    @(negedge clk);
    checkOutput("end_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
